fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-low.
REQ-003 StallD  input  1  hazard unit: hold decode-stage outputs and fetch PC.
REQ-004 FlushD  input  1  hazard unit: replace decode-stage outputs with a bubble.
REQ-005 PCSrcE  input  1  branch/jump taken in Execute; redirect fetch.
REQ-006 PCTargetE  input  32  redirect target; bits [1:0] SHALL be treated as 00.
REQ-007 imem_req  output  1  instruction memory request pending.
REQ-008 imem_addr  output  32  word-aligned fetch address.
REQ-009 imem_valid  input  1  memory response valid for the pending request.
REQ-010 imem_rdata  input  32  instruction word, qualified by imem_valid.
REQ-011 InstrD  output  32  instruction to decode stage (opcode in [6:0]).
REQ-012 PCD  output  32  PC of InstrD.
REQ-013 PCPlus4D  output  32  PCD+4.
REQ-014 ValidD  output  1  InstrD is a real instruction, not a bubble.

Function
REQ-015 Memory protocol: one outstanding request max; while imem_req=1, imem_addr SHALL stay stable until the cycle imem_valid=1 is sampled; response may arrive the same cycle or any later cycle.
REQ-016 States: IDLE, REQ, FULL, DROP; registers FetchPC (address of current/next request), PendPC (redirect target held during DROP), Buf (one-entry skid: instr+PC).
REQ-017 IDLE: imem_req=0; next cycle -> REQ.
REQ-018 REQ: imem_req=1, imem_addr=FetchPC.
REQ-019 REQ, imem_valid=1, PCSrcE=0, StallD=0: InstrD<=imem_rdata, PCD<=FetchPC, PCPlus4D<=FetchPC+4, ValidD<=1; FetchPC<=FetchPC+4; stay REQ (back-to-back fetch, 1 instr/cycle with zero-latency memory).
REQ-020 REQ, imem_valid=1, PCSrcE=0, StallD=1: Buf<=response; FetchPC<=FetchPC+4; -> FULL; D outputs held.
REQ-021 FULL: imem_req=0; StallD=0 -> D outputs<=Buf (ValidD=1), -> REQ; StallD=1 -> hold.
REQ-022 REQ, imem_valid=0, PCSrcE=1: PendPC<=PCTargetE; -> DROP.
REQ-023 DROP: imem_req=1 with old imem_addr; on imem_valid=1 response discarded, FetchPC<=PendPC, -> REQ; PCSrcE=1 again in DROP updates PendPC only.
REQ-024 REQ, imem_valid=1, PCSrcE=1 same cycle: response discarded, FetchPC<=PCTargetE, stay REQ.
REQ-025 FULL, PCSrcE=1: Buf discarded, FetchPC<=PCTargetE, -> REQ.
REQ-026 IDLE, PCSrcE=1: FetchPC<=PCTargetE, -> REQ.
REQ-027 Decode register priority per cycle: FlushD > StallD > load; FlushD=1 -> InstrD<=0x00000013, PCD<=0, PCPlus4D<=0, ValidD<=0.
REQ-028 No new instruction loads D while StallD=1; stall never drops or duplicates an instruction.
REQ-029 PC arithmetic modulo 2^32; 0xFFFFFFFC+4 wraps to 0x00000000.

Reset
REQ-030 rst=0 at a rising edge: state<=IDLE, FetchPC<=0x00000000, PendPC<=0, Buf cleared, InstrD<=0x00000013, PCD<=0, PCPlus4D<=0, ValidD<=0; imem_req SHALL be 0 the cycle after.
REQ-031 Reset mid-request abandons it; memory SHALL be reset concurrently by the system, so no stale response is expected.

Verification
REQ-032 Zero-latency memory returning addr-as-data, no stalls -> PCD=0,4,8,... on consecutive cycles, ValidD=1, InstrD=PCD.
REQ-033 Response at 0x8 arrives with StallD=1 for 3 cycles -> FULL, D holds 0x4 entry; after release PCD=0x8, then 0xC; no gap or duplicate.
REQ-034 PCSrcE=1, PCTargetE=0x103 while request 0x10 pending 2 more cycles -> imem_addr stays 0x10 until imem_valid, its data never reaches D, next imem_addr=0x100.
REQ-035 imem_valid and PCSrcE same cycle, target 0x40 -> response dropped, next imem_addr=0x40.
REQ-036 FlushD and StallD both 1 -> InstrD=0x00000013, ValidD=0; rst=0 mid-fetch -> all REQ-030 values next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory requests, a one-entry skid buffer for
// responses arriving under a decode stall, and redirect handling that drains in-flight requests.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] FULL = 2'd2;
  localparam logic [1:0] DROP = 2'd3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]  stateReg, stateNext;
  logic [31:0] fetchPcReg, fetchPcNext;
  logic [31:0] pendPcReg, pendPcNext;
  logic [31:0] bufInstrReg, bufInstrNext;
  logic [31:0] bufPcReg, bufPcNext;
  logic        loadD;
  logic [31:0] loadInstr, loadPc;
  logic [31:0] targetAligned;

  assign targetAligned = {PCTargetE[31:2], 2'b00};
  assign imem_req      = (stateReg == REQ) || (stateReg == DROP);
  assign imem_addr     = fetchPcReg;

  always_comb begin
    stateNext    = stateReg;
    fetchPcNext  = fetchPcReg;
    pendPcNext   = pendPcReg;
    bufInstrNext = bufInstrReg;
    bufPcNext    = bufPcReg;
    loadD        = 1'b0;
    loadInstr    = imem_rdata;
    loadPc       = fetchPcReg;
    case (stateReg)
      IDLE: begin
        stateNext = REQ;
        if (PCSrcE) fetchPcNext = targetAligned;
      end
      REQ: begin
        if (PCSrcE) begin
          // A redirect with no response yet must wait out the pending request in DROP.
          if (imem_valid) begin
            fetchPcNext = targetAligned;
          end else begin
            pendPcNext = targetAligned;
            stateNext  = DROP;
          end
        end else if (imem_valid) begin
          fetchPcNext = fetchPcReg + 32'd4;
          if (StallD) begin
            bufInstrNext = imem_rdata;
            bufPcNext    = fetchPcReg;
            stateNext    = FULL;
          end else begin
            loadD = 1'b1;
          end
        end
      end
      FULL: begin
        if (PCSrcE) begin
          fetchPcNext = targetAligned;
          stateNext   = REQ;
        end else if (!StallD) begin
          loadD     = 1'b1;
          loadInstr = bufInstrReg;
          loadPc    = bufPcReg;
          stateNext = REQ;
        end
      end
      DROP: begin
        // The newest redirect wins, even when it coincides with the stale response.
        if (imem_valid) begin
          fetchPcNext = PCSrcE ? targetAligned : pendPcReg;
          stateNext   = REQ;
        end else if (PCSrcE) begin
          pendPcNext = targetAligned;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stateReg    <= IDLE;
      fetchPcReg  <= 32'd0;
      pendPcReg   <= 32'd0;
      bufInstrReg <= 32'd0;
      bufPcReg    <= 32'd0;
    end else begin
      stateReg    <= stateNext;
      fetchPcReg  <= fetchPcNext;
      pendPcReg   <= pendPcNext;
      bufInstrReg <= bufInstrNext;
      bufPcReg    <= bufPcNext;
    end
  end

  // When decode advances without a new instruction it receives a bubble, so nothing repeats.
  always_ff @(posedge clk) begin
    if (!rst || FlushD) begin
      InstrD   <= NOP;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      if (loadD) begin
        InstrD   <= loadInstr;
        PCD      <= loadPc;
        PCPlus4D <= loadPc + 32'd4;
        ValidD   <= 1'b1;
      end else begin
        InstrD   <= NOP;
        PCD      <= 32'd0;
        PCPlus4D <= 32'd0;
        ValidD   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: addr-as-data memory with programmable latency, a program-order
// delivery model checked every cycle, and directed scenarios with literal expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int compared = 0;
  int mismatched = 0;
  int lat = 0;
  int waitCnt = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  // Memory answers after `lat` waiting cycles and returns the address as the instruction.
  always_comb begin
    imem_valid = imem_req && (waitCnt >= lat);
    imem_rdata = imem_addr;
  end

  always_ff @(posedge clk) begin
    if (!imem_req || imem_valid) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order model: every instruction entering decode must be the next sequential PC
  // of the current path (reset or latest redirect); stalls hold, flushes/redirects bubble.
  bit          have = 1'b0;
  logic        pRst, pStall, pFlush, pPc, pReq, pValid, pVd;
  logic [31:0] pTgt, pAddr, pInstr, pPcd, pPc4;
  logic [31:0] expNext = 32'd0;

  initial begin
    forever begin
      @(negedge clk);
      if (have) begin
        if (!pRst) begin
          chk("rst_req", 32'(imem_req), 32'd0);
          chk("rst_instr", InstrD, 32'h13);
          chk("rst_pcd", PCD, 32'd0);
          chk("rst_pc4", PCPlus4D, 32'd0);
          chk("rst_valid", 32'(ValidD), 32'd0);
          expNext = 32'd0;
        end else if (pFlush || (!pStall && (pPc || !ValidD))) begin
          chk("m_bub_instr", InstrD, 32'h13);
          chk("m_bub_pcd", PCD, 32'd0);
          chk("m_bub_pc4", PCPlus4D, 32'd0);
          chk("m_bub_valid", 32'(ValidD), 32'd0);
        end else if (pStall) begin
          chk("m_hold_instr", InstrD, pInstr);
          chk("m_hold_pcd", PCD, pPcd);
          chk("m_hold_pc4", PCPlus4D, pPc4);
          chk("m_hold_valid", 32'(ValidD), 32'(pVd));
        end else begin
          chk("m_pcd", PCD, expNext);
          chk("m_instr", InstrD, expNext);
          chk("m_pc4", PCPlus4D, expNext + 32'd4);
          $display("deliver PCD=%h InstrD=%h PCPlus4D=%h", PCD, InstrD, PCPlus4D);
          expNext = expNext + 32'd4;
        end
        if (pRst && pPc) expNext = pTgt & 32'hFFFF_FFFC;
        if (pRst && pReq && !pValid) begin
          chk("addr_stable_req", 32'(imem_req), 32'd1);
          chk("addr_stable", imem_addr, pAddr);
        end
        if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
      end
      pRst = rst; pStall = StallD; pFlush = FlushD; pPc = PCSrcE; pTgt = PCTargetE;
      pReq = imem_req; pValid = imem_valid; pAddr = imem_addr;
      pInstr = InstrD; pPcd = PCD; pPc4 = PCPlus4D; pVd = ValidD;
      have = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
    tick(); tick();
    chk("reset_req", 32'(imem_req), 32'd0);
    chk("reset_valid", 32'(ValidD), 32'd0);
    chk("reset_instr", InstrD, 32'h13);
    rst = 1'b1;
    tick();
    chk("idle_to_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'd0);

    // Zero-latency streaming: one instruction per cycle.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stream_pcd", PCD, 32'(4 * i));
      chk("stream_instr", InstrD, 32'(4 * i));
      chk("stream_pc4", PCPlus4D, 32'(4 * i + 4));
    end

    // Response for 0x8 arrives under a 3-cycle stall.
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_pcd", PCD, 32'h4);
      chk("stall_full_req", 32'(imem_req), 32'd0);
    end
    StallD = 1'b0;
    tick();
    chk("skid_pcd", PCD, 32'h8);
    tick();
    chk("after_skid_pcd", PCD, 32'hC);

    // Redirect to 0x103 while 0x10 is still pending for two more cycles.
    lat = 2; PCSrcE = 1'b1; PCTargetE = 32'h103;
    tick();
    PCSrcE = 1'b0;
    chk("drop_addr0", imem_addr, 32'h10);
    chk("drop_bubble", 32'(ValidD), 32'd0);
    tick();
    chk("drop_addr1", imem_addr, 32'h10);
    lat = 0;
    tick();
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_bubble", 32'(ValidD), 32'd0);
    tick();
    chk("redir_pcd", PCD, 32'h100);

    // Response and redirect in the same cycle.
    PCSrcE = 1'b1; PCTargetE = 32'h40;
    tick();
    PCSrcE = 1'b0;
    chk("same_cyc_addr", imem_addr, 32'h40);
    chk("same_cyc_bubble", 32'(ValidD), 32'd0);
    tick();
    chk("same_cyc_pcd", PCD, 32'h40);

    // Flush beats stall.
    StallD = 1'b1; FlushD = 1'b1;
    tick();
    chk("flush_instr", InstrD, 32'h13);
    chk("flush_valid", 32'(ValidD), 32'd0);
    chk("flush_pcd", PCD, 32'd0);
    StallD = 1'b0; FlushD = 1'b0;
    tick();
    chk("post_flush_pcd", PCD, 32'h44);

    // Redirect while the skid buffer is full.
    StallD = 1'b1;
    tick();
    chk("full_hold_pcd", PCD, 32'h44);
    StallD = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h200;
    tick();
    PCSrcE = 1'b0;
    chk("full_redir_addr", imem_addr, 32'h200);
    chk("full_redir_valid", 32'(ValidD), 32'd0);
    tick();
    chk("full_redir_pcd", PCD, 32'h200);

    // PC wrap-around.
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFA;
    tick();
    PCSrcE = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    tick();
    chk("wrap_pcd0", PCD, 32'hFFFF_FFF8);
    chk("wrap_pc40", PCPlus4D, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pcd1", PCD, 32'hFFFF_FFFC);
    chk("wrap_pc41", PCPlus4D, 32'h0);
    tick();
    chk("wrap_pcd2", PCD, 32'h0);

    // Reset in the middle of a pending request, then redirect straight out of IDLE.
    lat = 3;
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_instr", InstrD, 32'h13);
    chk("midrst_pcd", PCD, 32'd0);
    chk("midrst_pc4", PCPlus4D, 32'd0);
    chk("midrst_valid", 32'(ValidD), 32'd0);
    rst = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h80; lat = 0;
    tick();
    PCSrcE = 1'b0;
    chk("idle_redir_req", 32'(imem_req), 32'd1);
    chk("idle_redir_addr", imem_addr, 32'h80);
    tick();
    chk("idle_redir_pcd", PCD, 32'h80);

    // Mixed stalls, latencies and redirects, checked by the model alone.
    for (int i = 0; i < 60; i++) begin
      StallD    = ((i % 5) == 2) || ((i % 7) == 3);
      PCSrcE    = ((i % 11) == 6);
      FlushD    = PCSrcE;
      PCTargetE = 32'h300 + 32'(i * 8) + 32'd1;
      lat       = i % 3;
      tick();
    end
    StallD = 1'b0; PCSrcE = 1'b0; FlushD = 1'b0; lat = 0;
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
